// File: rtl/pwm_fader_pkg.sv
// Shared mode and direction encodings for the multi-channel PWM fader.
package pwm_fader_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_fader_if.sv
// Configuration write bus: one-cycle strobe carrying channel, mode and level.
interface pwm_fader_if
    import pwm_fader_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 3
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_we;
    logic [CW-1:0]    cfg_ch;
    mode_t            cfg_mode;
    logic [WIDTH-1:0] cfg_level;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_level
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_mode, cfg_level
    );

endinterface

// File: rtl/pwm_fader_channel.sv
// One PWM channel: mode/target/level/dir state, duty shadow and output flop.
module pwm_fader_channel
    import pwm_fader_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] counter,
    input  logic             wrap,
    input  logic             tick,
    input  logic             we,
    input  mode_t            mode_in,
    input  logic [WIDTH-1:0] level_in,
    output logic             pwm,
    output logic             fading
);
    localparam logic INV = (INVERT != 0);

    mode_t            mode;
    dir_t             dir;
    dir_t             br_dir;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] ramp_nxt;
    logic [WIDTH-1:0] br_nxt;
    logic             down;

    // A level at or above target always heads down, covering a lowered target.
    always_comb begin
        down = (level != '0) && (dir == DIR_DOWN || level >= target);
        br_nxt = down ? level - 1'b1 : level + 1'b1;
        if (br_nxt == target)
            br_dir = DIR_DOWN;
        else if (br_nxt == '0)
            br_dir = DIR_UP;
        else
            br_dir = down ? DIR_DOWN : DIR_UP;
        if (level < target)
            ramp_nxt = level + 1'b1;
        else if (level > target)
            ramp_nxt = level - 1'b1;
        else
            ramp_nxt = level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode   <= MODE_OFF;
            dir    <= DIR_UP;
            target <= '0;
            level  <= '0;
            duty   <= '0;
            pwm    <= INV;
        end else begin
            if (wrap)
                duty <= level;
            pwm <= (counter < duty) ^ INV;
            // A write on a tick cycle wins; this channel skips that tick.
            if (we) begin
                mode   <= mode_in;
                target <= level_in;
                unique case (1'b1)
                    mode_in == MODE_OFF:     level <= '0;
                    mode_in == MODE_STATIC:  level <= level_in;
                    mode_in == MODE_BREATHE: dir <= DIR_UP;
                    default: ;
                endcase
            end else if (tick) begin
                unique case (1'b1)
                    mode == MODE_RAMP: level <= ramp_nxt;
                    mode == MODE_BREATHE: begin
                        if (!(target == '0 && level == '0)) begin
                            level <= br_nxt;
                            dir   <= br_dir;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fading = (mode == MODE_RAMP && level != target)
                 || (mode == MODE_BREATHE && target != '0);

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel PWM with fade engine: shared period counter and fade prescaler.
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 3,
    parameter int FADE_DIV = 16,
    parameter int INVERT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    pwm_fader_if.slave          cfg,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic [CHANNELS-1:0] fading
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(FADE_DIV - 1);

    logic [WIDTH-1:0] counter;
    logic [PW-1:0]    presc;
    logic             wrap;
    logic             tick;

    assign wrap = (counter == '1);
    assign tick = wrap && (presc == PLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            counter      <= '0;
            presc        <= '0;
            period_start <= 1'b0;
        end else begin
            counter      <= counter + 1'b1;
            period_start <= (counter == '0);
            if (wrap)
                presc <= (presc == PLAST) ? '0 : presc + 1'b1;
        end
    end

    // Channel indices beyond CHANNELS never match, so such writes vanish.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_fader_channel #(
            .WIDTH  (WIDTH),
            .INVERT (INVERT)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .counter  (counter),
            .wrap     (wrap),
            .tick     (tick),
            .we       (cfg.cfg_we && (cfg.cfg_ch == CW'(i))),
            .mode_in  (cfg.cfg_mode),
            .level_in (cfg.cfg_level),
            .pwm      (pwm_out[i]),
            .fading   (fading[i])
        );
    end

endmodule

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
Multi-channel PWM driver with a per-channel fade engine. It drives LED pins, for example an RGB LED from one block.
- One shared free-running period counter and one fade prescaler serve all channels.
- Each channel has its own mode, target level, working level and glitch-free duty shadow register.
- It generalises the fixed single-channel breathing PWM: parametrised width, channel count, fade rate, output polarity and four runtime modes.

Parameters:
WIDTH, 12, PWM resolution in bits; period = 2^WIDTH clk cycles
CHANNELS, 3, number of independent PWM outputs (1..16)
FADE_DIV, 16, PWM periods per fade tick (>=1)
INVERT, 1, 1 = outputs active-low (LED sinks current), 0 = active-high

Ports:
clk  in  1  system clock (48 MHz HFOSC domain)
reset  in  1  synchronous, active-high
cfg_we  in  1  configuration write strobe, one cycle
cfg_ch  in  max(1,$clog2(CHANNELS))  channel select for write
cfg_mode  in  2  mode for selected channel
cfg_level  in  WIDTH  target/peak level for selected channel
pwm_out  out  CHANNELS  registered PWM outputs
period_start  out  1  registered pulse, high one cycle per PWM period
fading  out  CHANNELS  channel level still moving

Behaviour:
- Counter: WIDTH-bit free-running; wraps from 2^WIDTH-1 to 0.
- period_start is registered and is 1 in the cycle after counter==0.
- Prescaler counts wraps 0..FADE_DIV-1. The fade tick is a one-cycle internal strobe at counter==2^WIDTH-1 when the prescaler is at FADE_DIV-1.
- Duty shadow: duty[i] <= level[i] only when counter==2^WIDTH-1. Level changes never alter an in-progress period.
- Output: pwm_out[i] <= (counter < duty[i]) ^ INVERT.
  - One cycle latency from the compare.
  - duty=0 gives 0% active.
  - duty=2^WIDTH-1 gives (2^WIDTH-1)/2^WIDTH active; 100% is not reachable by design.
- Modes (cfg_mode):
  - 0 OFF: level forced to 0 on write.
  - 1 STATIC: level <= cfg_level on write, no fading.
  - 2 RAMP: on each tick, level moves 1 toward target; holds when equal.
  - 3 BREATHE: on each tick, level +1 if dir=up, -1 if dir=down.
    - dir <= down when the new level == target.
    - dir <= up when the new level == 0.
    - target==0 holds the level at 0.
    - If level > target (target lowered mid-breathe), dir is forced down and the level descends by ticks.
- Write: cfg_we=1 loads mode and target into channel cfg_ch on that edge.
  - BREATHE writes set dir=up.
  - The level is not reset by RAMP or BREATHE writes.
  - cfg_ch >= CHANNELS: write ignored.
- Write and tick in the same cycle: the write takes effect for the addressed channel; that channel skips that tick. Other channels tick normally.
- Arithmetic: level stays within 0..2^WIDTH-1; no wrap-around on +1 or -1.
- fading[i] = (mode==RAMP && level!=target) || (mode==BREATHE && target!=0). Combinational from registers.
- Reset values:
  - counter, prescaler, level, target, duty = 0
  - mode = OFF, dir = up
  - pwm_out = {CHANNELS{INVERT}} (inactive)
  - period_start = 0, fading = 0
- Reset asserted mid-period or mid-fade returns everything to reset values on the next edge. The first period starts with counter=0 after reset deasserts.

Decomposition:
- Package pwm_fader_pkg holds:
  - mode constants MODE_OFF=0, MODE_STATIC=1, MODE_RAMP=2, MODE_BREATHE=3
  - DIR_UP/DIR_DOWN
- Sub-module pwm_fader_channel, instantiated CHANNELS times by generate:
  - owns mode, target, level, dir, duty, compare and output flop
  - inputs: shared counter, wrap strobe, tick strobe, decoded write enable
- Top level keeps the counter, prescaler, period_start and write decode.

Test Plan:
(all with WIDTH=4, CHANNELS=3, FADE_DIV=2, INVERT=0 unless stated)
- Reset held 5 cycles, then released -> pwm_out=000, fading=000, period_start first high 1 cycle after counter==0, then every 16 cycles.
- STATIC ch1 level 5 written mid-period -> current period unchanged; next period pwm_out[1] high exactly 5 of 16 cycles; level 0 gives 0 high cycles; level 15 gives 15.
- RAMP ch0 target 3 from 0 -> duty steps 1,2,3, one step every 32 cycles; fading[0] drops after reaching 3; RAMP back to 0 descends, with no underflow.
- BREATHE ch2 target 4 -> level sequence 1,2,3,4,3,2,1,0,1... per tick; rewriting target 2 while level=4 descends to 2, then oscillates 0..2.
- Write at the tick cycle to ch0, plus cfg_ch=3 write -> ch0 skips that tick while ch1/ch2 step; cfg_ch=3 changes no state.
- INVERT=1, reset asserted mid-fade -> pwm_out=111 the next cycle, all levels 0; level 5 gives 11 high / 5 low per period.
